cpu_controller: RTL

- Multi-cycle control FSM for the 16-bit CPU.
- Owns the program counter and instruction register, and sequences the datapath per instruction: fetch, decode, execute, memory.
- Drives register-file write enable, flag-register write enable, memory address/write and writeback select.
- The decoder, ALU and register file are fed from its outputs. It handles LOAD, STOR, Bcond and Jcond, which the decoder does not handle.

---
 rtl/cpu_ctrl_pkg.sv | 63 ++++++
 rtl/cond_eval.sv | 23 ++
 rtl/cpu_controller.sv | 113 +++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - state encodings, opcode fields and instruction classifiers for cpu_controller
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_LDWB   = 3'd4
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_MEMJ  = 4'h4;
  localparam logic [3:0] OP_SHIFT = 4'h8;
  localparam logic [3:0] OP_CMPI  = 4'hB;
  localparam logic [3:0] OP_BCOND = 4'hC;

  localparam logic [3:0] EXT_LOAD  = 4'h0;
  localparam logic [3:0] EXT_STOR  = 4'h4;
  localparam logic [3:0] EXT_JCOND = 4'hC;
  localparam logic [3:0] EXT_CMP   = 4'hB;
  localparam logic [3:0] EXT_LSH   = 4'h4;
  localparam logic [3:0] EXT_ASH   = 4'h6;

  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_GT = 4'h6;
  localparam logic [3:0] CC_LE = 4'h7;
  localparam logic [3:0] CC_UC = 4'hE;

  function automatic logic is_load(input logic [15:0] i);
    return (i[15:12] == OP_MEMJ) && (i[7:4] == EXT_LOAD);
  endfunction

  function automatic logic is_stor(input logic [15:0] i);
    return (i[15:12] == OP_MEMJ) && (i[7:4] == EXT_STOR);
  endfunction

  function automatic logic is_jcond(input logic [15:0] i);
    return (i[15:12] == OP_MEMJ) && (i[7:4] == EXT_JCOND);
  endfunction

  function automatic logic is_bcond(input logic [15:0] i);
    return i[15:12] == OP_BCOND;
  endfunction

  // Everything the ALU executes: R-type, the immediate opcodes and the two register shifts.
  function automatic logic is_alu(input logic [15:0] i);
    logic res;
    res = 1'b0;
    case (i[15:12])
      4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'hE: res = 1'b1;
      OP_SHIFT: res = (i[7:4] == EXT_LSH) || (i[7:4] == EXT_ASH);
      default:  res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic is_cmp(input logic [15:0] i);
    return (i[15:12] == OP_CMPI) || ((i[15:12] == OP_RTYPE) && (i[7:4] == EXT_CMP));
  endfunction

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - branch/jump condition evaluation from stored Z and N flags
module cond_eval
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       flag_z,
  input  logic       flag_n,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_EQ:   taken = flag_z;
      CC_NE:   taken = ~flag_z;
      CC_GT:   taken = flag_n;
      CC_LE:   taken = ~flag_n;
      CC_UC:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - multi-cycle fetch/decode/execute/memory control FSM owning pc and ir
module cpu_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            run,
  input  logic [15:0]     mem_rdata,
  input  logic [15:0]     src_data,
  input  logic [15:0]     dst_data,
  input  logic            flag_z,
  input  logic            flag_n,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     ir,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_we,
  output logic [15:0]     mem_wdata,
  output logic            reg_we,
  output logic            wb_sel,
  output logic            flag_we,
  output logic [2:0]      state
);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q;
  logic            ir_load;
  logic            taken;
  logic [PC_W-1:0] pc_inc, pc_branch, pc_jump;

  cond_eval u_cond_eval (
    .cond   (ir_q[11:8]),
    .flag_z (flag_z),
    .flag_n (flag_n),
    .taken  (taken)
  );

  assign pc_inc    = pc_q + PC_W'(1);
  // Branch displacement is relative to the branch's own address, not pc+1.
  assign pc_branch = pc_q + PC_W'($signed(ir_q[7:0]));
  assign pc_jump   = PC_W'(src_data);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (ir_load) ir_q <= mem_rdata;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_load  = 1'b0;
    mem_addr = pc_q;
    mem_we   = 1'b0;
    reg_we   = 1'b0;
    wb_sel   = 1'b0;
    flag_we  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (run) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        // ir is not loaded yet, so the memory class is decided from the read data directly.
        ir_load = 1'b1;
        state_d = (is_load(mem_rdata) || is_stor(mem_rdata)) ? ST_MEM : ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_inc;
        if (is_alu(ir_q)) begin
          flag_we = 1'b1;
          reg_we  = ~is_cmp(ir_q);
        end else if (is_bcond(ir_q)) begin
          if (taken) pc_d = pc_branch;
        end else if (is_jcond(ir_q)) begin
          if (taken) pc_d = pc_jump;
        end
      end
      ST_MEM: begin
        mem_addr = PC_W'(src_data);
        if (is_stor(ir_q)) begin
          mem_we  = 1'b1;
          pc_d    = pc_inc;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_LDWB;
        end
      end
      ST_LDWB: begin
        reg_we  = 1'b1;
        wb_sel  = 1'b1;
        pc_d    = pc_inc;
        state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  assign pc        = pc_q;
  assign ir        = ir_q;
  assign mem_wdata = dst_data;
  assign state     = state_q;

endmodule
